// File: rtl/way_fill_pkg.sv
// Shared state type and sizing helpers for way_fill_writer.
// The critical-word-first variant is selected by defining WAY_FILL_CRITICAL_WORD_EN.
package way_fill_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } state_e;

   function automatic int beats_f(input int line_bytes, input int beat_bytes);
      return line_bytes / beat_bytes;
   endfunction

   // Index width over n items; never below one bit so a single-beat line still has a counter.
   function automatic int idx_width_f(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/way_fill_writer_onehot_checker.sv
// Flags whether a vector has exactly one bit set; used to qualify the requested way.
module onehot_checker #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_vec,
   output logic             o_is_onehot
);

   // Clearing the lowest set bit leaves zero only for a single-bit vector.
   assign o_is_onehot = (i_vec != '0) && ((i_vec & (i_vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/way_fill_writer.sv
// Assembles a refill line from BEAT_BYTES-wide beats and writes it into one way with a one-hot enable.
// Define WAY_FILL_CRITICAL_WORD_EN to add i_req_beat, the beat index the fill starts at.
module way_fill_writer
   import way_fill_pkg::*;
#(
   parameter  int LINE_SIZE_BYTES = 64,
   parameter  int WAYS            = 4,
   parameter  int BEAT_BYTES      = 8,
   localparam int BEATS           = beats_f(LINE_SIZE_BYTES, BEAT_BYTES),
   localparam int BEAT_IDX_W      = idx_width_f(BEATS)
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_req_valid,
   output logic                         o_req_ready,
   input  logic [WAYS-1:0]              i_req_way,
`ifdef WAY_FILL_CRITICAL_WORD_EN
   input  logic [BEAT_IDX_W-1:0]        i_req_beat,
`endif
   input  logic                         i_beat_valid,
   output logic                         o_beat_ready,
   input  logic [BEAT_BYTES*8-1:0]      i_beat_data,
   output logic [WAYS-1:0]              o_wr_en,
   output logic [LINE_SIZE_BYTES*8-1:0] o_wr_data,
   output logic                         o_done,
   output logic                         o_err
);

   localparam int                    BEAT_W   = BEAT_BYTES * 8;
   localparam int                    LINE_W   = LINE_SIZE_BYTES * 8;
   localparam logic [BEAT_IDX_W-1:0] LAST_IDX = BEAT_IDX_W'(BEATS - 1);

   state_e                state_q, state_d;
   logic [WAYS-1:0]       way_q, way_d;
   logic [BEAT_IDX_W-1:0] idx_q, idx_d;
   logic [BEAT_IDX_W-1:0] cnt_q, cnt_d;
   logic [LINE_W-1:0]     line_q, line_d;
   logic                  err_q, err_d;

   logic                  way_onehot;
   logic [BEAT_IDX_W-1:0] start_idx;
   logic                  req_ready;
   logic                  beat_ready;
   logic                  req_fire;
   logic                  req_ok;
   logic                  beat_fire;
   logic                  last_beat;

   onehot_checker #(
      .WIDTH (WAYS)
   ) u_way_check (
      .i_vec       (i_req_way),
      .o_is_onehot (way_onehot)
   );

`ifdef WAY_FILL_CRITICAL_WORD_EN
   // Out-of-range start indices only exist when BEATS is not a power of two; they start at 0.
   if (BEATS == (1 << BEAT_IDX_W)) begin : g_start_direct
      assign start_idx = i_req_beat;
   end else begin : g_start_clamp
      assign start_idx = (i_req_beat > LAST_IDX) ? '0 : i_req_beat;
   end
`else
   assign start_idx = '0;
`endif

   assign req_fire  = i_req_valid & req_ready;
   assign req_ok    = req_fire & way_onehot;
   assign beat_fire = i_beat_valid & beat_ready;
   assign last_beat = beat_fire && (cnt_q == LAST_IDX);

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: each always_comb assigns its defaults first so no path leaves a signal unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_ok)    state_d = FILL;
         FILL:    if (last_beat) state_d = WRITE;
         WRITE:                  state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // A reset arriving during WRITE suppresses the write in that same cycle.
   always_comb begin
      req_ready  = 1'b0;
      beat_ready = 1'b0;
      o_wr_en    = '0;
      o_done     = 1'b0;
      case (state_q)
         IDLE:  req_ready  = 1'b1;
         FILL:  beat_ready = 1'b1;
         WRITE: begin
            if (!i_rst) begin
               o_wr_en = way_q;
               o_done  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      way_d  = way_q;
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      line_d = line_q;
      err_d  = req_fire & ~way_onehot;
      if (req_ok) begin
         way_d = i_req_way;
         idx_d = start_idx;
         cnt_d = '0;
      end else if (beat_fire) begin
         line_d[int'(idx_q) * BEAT_W +: BEAT_W] = i_beat_data;
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + BEAT_IDX_W'(1);
         cnt_d = last_beat ? '0 : cnt_q + BEAT_IDX_W'(1);
      end
   end

   // NOTE: the wide line buffer is reset too, so an aborted fill never leaves stale data on o_wr_data.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         way_q  <= '0;
         idx_q  <= '0;
         cnt_q  <= '0;
         line_q <= '0;
         err_q  <= 1'b0;
      end else begin
         way_q  <= way_d;
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         line_q <= line_d;
         err_q  <= err_d;
      end
   end

   assign o_req_ready  = req_ready;
   assign o_beat_ready = beat_ready;
   assign o_wr_data    = line_q;
   assign o_err        = err_q;

endmodule

// File: tb/tb_way_fill_writer.sv
// Scoreboard bench for way_fill_writer: stimulus pushes expected writes/errors, a monitor pops and compares.
// Define WAY_FILL_CRITICAL_WORD_EN to also exercise the critical-word-first start index.
module tb_way_fill_writer;
   import way_fill_pkg::*;

   localparam int LINE_SIZE_BYTES = 64;
   localparam int WAYS            = 4;
   localparam int BEAT_BYTES      = 8;
   localparam int BEATS           = LINE_SIZE_BYTES / BEAT_BYTES;
   localparam int BEAT_W          = BEAT_BYTES * 8;
   localparam int LINE_W          = LINE_SIZE_BYTES * 8;
   localparam int IDX_W           = idx_width_f(BEATS);

   typedef struct {
      logic [WAYS-1:0]   way;
      logic [LINE_W-1:0] data;
      int                req_cyc;
      bit                chk_lat;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic [WAYS-1:0]   req_way;
`ifdef WAY_FILL_CRITICAL_WORD_EN
   logic [IDX_W-1:0]  req_beat;
`endif
   logic              beat_valid;
   logic              beat_ready;
   logic [BEAT_W-1:0] beat_data;
   logic [WAYS-1:0]   wr_en;
   logic [LINE_W-1:0] wr_data;
   logic              done;
   logic              err;

   int                n_checks = 0;
   int                n_fail   = 0;
   int                cyc      = 0;
   bit                mon_en   = 0;
   exp_t              sb_q[$];
   int                err_q[$];
   logic [BEAT_W-1:0] cur_beats [BEATS];
   exp_t              mon_e;

   way_fill_writer #(
      .LINE_SIZE_BYTES (LINE_SIZE_BYTES),
      .WAYS            (WAYS),
      .BEAT_BYTES      (BEAT_BYTES)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_way    (req_way),
`ifdef WAY_FILL_CRITICAL_WORD_EN
      .i_req_beat   (req_beat),
`endif
      .i_beat_valid (beat_valid),
      .o_beat_ready (beat_ready),
      .i_beat_data  (beat_data),
      .o_wr_en      (wr_en),
      .o_wr_data    (wr_data),
      .o_done       (done),
      .o_err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference line: beat k of the fill lands in slot (start + k) mod BEATS.
   function automatic logic [LINE_W-1:0] model_line(input int start);
      logic [LINE_W-1:0] l;
      l = '0;
      for (int k = 0; k < BEATS; k++) l[((start + k) % BEATS) * BEAT_W +: BEAT_W] = cur_beats[k];
      return l;
   endfunction

   // Monitor: every presented write or error is matched against the oldest expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         if (wr_en != '0 || done) begin
            if (sb_q.size() == 0) begin
               check("unexpected_write", LINE_W'(wr_en), '0);
            end else begin
               mon_e = sb_q.pop_front();
               check("wr_en", LINE_W'(wr_en), LINE_W'(mon_e.way));
               check("done_with_wr_en", LINE_W'(done), 1);
               check("wr_data", wr_data, mon_e.data);
               if (mon_e.chk_lat) check("latency_edges", LINE_W'(cyc - mon_e.req_cyc), BEATS);
            end
         end
         if (err) begin
            if (err_q.size() == 0) check("unexpected_err", LINE_W'(err), 0);
            else check("err_cycle", LINE_W'(cyc), LINE_W'(err_q.pop_front()));
         end
      end
   end

   task automatic do_reset_pulse();
      rst        = 1'b1;
      req_valid  = 1'b0;
      beat_valid = 1'b0;
      tick();
      rst = 1'b0;
      check("reset_req_ready", LINE_W'(req_ready), 1);
      check("reset_beat_ready", LINE_W'(beat_ready), 0);
      check("reset_wr_data", wr_data, '0);
   endtask

   // One fill transaction. bubble_mode: 0 none, 1 alternate, 2 random.
   // rst_after: -1 none, k<BEATS reset after k beats, BEATS reset in the write cycle.
   task automatic do_fill(input logic [WAYS-1:0] way, input int start, input int bubble_mode,
                          input bit chk_lat, input bit hold_req, input int rst_after, input bit preset);
      int eff_start;
      int req_cyc;
`ifdef WAY_FILL_CRITICAL_WORD_EN
      eff_start = start;
      req_beat  = IDX_W'(start);
`else
      eff_start = 0;
`endif
      if (!preset) for (int k = 0; k < BEATS; k++) cur_beats[k] = {$urandom, $urandom};
      req_valid = 1'b1;
      req_way   = way;
      for (int t = 0; t < 20 && !req_ready; t++) tick();
      check("req_ready_wait", LINE_W'(req_ready), 1);
      tick();
      req_cyc = cyc;
      if (!hold_req) req_valid = 1'b0;
      if ($countones(way) != 1) begin
         err_q.push_back(req_cyc);
         req_valid = 1'b0;
         check("req_ready_after_err", LINE_W'(req_ready), 1);
         check("beat_ready_after_err", LINE_W'(beat_ready), 0);
         return;
      end
      if (rst_after < 0)
         sb_q.push_back(exp_t'{way: way, data: model_line(eff_start), req_cyc: req_cyc, chk_lat: chk_lat});
      check("req_ready_in_fill", LINE_W'(req_ready), 0);
      for (int k = 0; k < BEATS; k++) begin
         if (k == rst_after) begin
            do_reset_pulse();
            return;
         end
         if (bubble_mode == 1 || (bubble_mode == 2 && $urandom_range(0, 2) == 0)) begin
            beat_valid = 1'b0;
            tick();
         end
         beat_valid = 1'b1;
         beat_data  = cur_beats[k];
         for (int t = 0; t < 20 && !beat_ready; t++) tick();
         check("beat_ready_wait", LINE_W'(beat_ready), 1);
         tick();
      end
      beat_valid = 1'b0;
      req_valid  = 1'b0;
      if (rst_after == BEATS) begin
         do_reset_pulse();
         return;
      end
      for (int t = 0; t < 4 * BEATS + 10 && sb_q.size() != 0; t++) tick();
      check("write_issued", LINE_W'(sb_q.size()), 0);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_way    = '0;
      beat_valid = 1'b0;
      beat_data  = '0;
`ifdef WAY_FILL_CRITICAL_WORD_EN
      req_beat   = '0;
`endif
      repeat (3) tick();
      rst = 1'b0;
      check("rst_req_ready", LINE_W'(req_ready), 1);
      check("rst_beat_ready", LINE_W'(beat_ready), 0);
      check("rst_wr_en", LINE_W'(wr_en), 0);
      check("rst_done", LINE_W'(done), 0);
      check("rst_err", LINE_W'(err), 0);
      check("rst_wr_data", wr_data, '0);
      mon_en = 1'b1;

      // Basic fill with beats 0..7, exact latency checked.
      for (int k = 0; k < BEATS; k++) cur_beats[k] = BEAT_W'(k);
      do_fill(4'b0100, 0, 0, 1, 0, -1, 1);

      // Bad selects back to back.
      do_fill(4'b0110, 0, 0, 0, 0, -1, 0);
      do_fill(4'b0000, 0, 0, 0, 0, -1, 0);
      repeat (2) tick();
      check("bad_sel_err_seen", LINE_W'(err_q.size()), 0);

      // Bubbles on every other cycle.
      do_fill(4'b0010, 0, 1, 0, 0, -1, 0);

      // Reset after three beats, then a clean fill into way 0.
      do_fill(4'b1000, 0, 0, 0, 0, 3, 0);
      do_fill(4'b0001, 0, 0, 1, 0, -1, 0);

      // Reset landing in the write cycle.
      do_fill(4'b0100, 0, 0, 0, 0, BEATS, 0);

      // Beats offered in IDLE are ignored; request held high through FILL.
      beat_valid = 1'b1;
      beat_data  = {$urandom, $urandom};
      for (int i = 0; i < 3; i++) begin
         check("beat_ready_idle", LINE_W'(beat_ready), 0);
         tick();
      end
      beat_valid = 1'b0;
      do_fill(4'b1000, 0, 0, 1, 1, -1, 0);

`ifdef WAY_FILL_CRITICAL_WORD_EN
      for (int k = 0; k < BEATS; k++) cur_beats[k] = 64'hA0A0_0000_0000_0000 + BEAT_W'(k + 10);
      do_fill(4'b0010, 5, 0, 1, 0, -1, 1);
`endif

      // Randomized fills, including occasional non-one-hot ways.
      for (int n = 0; n < 30; n++) begin
         logic [WAYS-1:0] w;
         if ($urandom_range(0, 4) == 0) w = WAYS'($urandom);
         else w = WAYS'(1) << $urandom_range(0, WAYS - 1);
         do_fill(w, $urandom_range(0, BEATS - 1), 2, 0, 1'($urandom_range(0, 1)), -1, 0);
      end

      repeat (5) tick();
      check("err_pending", LINE_W'(err_q.size()), 0);
      check("sb_pending", LINE_W'(sb_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
